// File: rtl/anim_pkg.sv
// Shared types and constants for the 7-segment activity animator.
// State encoding, modo encodings, segment patterns and width helpers.
package anim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } estado_t;

  localparam logic [1:0] MODO_FWD   = 2'b00;
  localparam logic [1:0] MODO_REV   = 2'b01;
  localparam logic [1:0] MODO_BLINK = 2'b10;
  localparam logic [1:0] MODO_OFF   = 2'b11;

  localparam logic [6:0] SEG_A   = 7'h01;
  localparam logic [6:0] SEG_B   = 7'h02;
  localparam logic [6:0] SEG_C   = 7'h04;
  localparam logic [6:0] SEG_D   = 7'h08;
  localparam logic [6:0] SEG_E   = 7'h10;
  localparam logic [6:0] SEG_F   = 7'h20;
  localparam logic [6:0] SEG_G   = 7'h40;
  localparam logic [6:0] SEG_ALL = SEG_A | SEG_B | SEG_C | SEG_D | SEG_E | SEG_F | SEG_G;

  localparam int unsigned N_FASES = 6;

  // Counter width for a given modulus, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Outer-ring segment for a spin position; g is never part of the ring.
  function automatic logic [6:0] seg_fase(input logic [2:0] i);
    case (i)
      3'd0:    return SEG_A;
      3'd1:    return SEG_B;
      3'd2:    return SEG_C;
      3'd3:    return SEG_D;
      3'd4:    return SEG_E;
      3'd5:    return SEG_F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/pulso_div.sv
// Modulo-N counter emitting a one-cycle tick on its last count.
// Used for the animation step prescaler and the digit scan divider.
module pulso_div
  import anim_pkg::*;
#(
  parameter int unsigned MODULO = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CW = clog2_min1(MODULO);
  localparam logic [CW-1:0] ULTIMO = CW'(MODULO - 1);

  logic [CW-1:0] cnt;

  assign tick_c = en && !clr && (cnt == ULTIMO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/anim_segmentos.sv
// Multi-digit rotating-segment activity animator with hold time.
// Request synchronisers, IDLE/RUN/HOLD control, phase/blink state and digit scan.
module anim_segmentos
  import anim_pkg::*;
#(
  parameter int unsigned N_DIG      = 4,
  parameter int unsigned PRESC      = 50000,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned HOLD_STEPS = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sinal,
  input  logic             botao,
  input  logic [1:0]       modo,
  output logic [6:0]       segmentos,
  output logic [N_DIG-1:0] anodo,
  output logic             ativo
);

  localparam int unsigned DW = clog2_min1(N_DIG);
  localparam int unsigned HW = clog2_min1(HOLD_STEPS + 1);
  localparam int unsigned SW = clog2_min1(N_FASES + N_DIG);
  localparam logic [N_DIG-1:0] ANODO_0 = N_DIG'(1);

  logic          sinal_m, sinal_s, botao_m, botao_s;
  logic          req;
  estado_t       estado_q, estado_d;
  logic          passo, scan_tick;
  logic [2:0]    fase;
  logic          pisca;
  logic [1:0]    modo_r;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] digito;
  logic [SW-1:0] soma;
  logic [2:0]    idx;
  logic [6:0]       seg_d;
  logic [N_DIG-1:0] anodo_d;
  logic             ativo_d;

  // Two-flop synchronisers on both asynchronous request inputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sinal_m <= 1'b0;
      sinal_s <= 1'b0;
      botao_m <= 1'b0;
      botao_s <= 1'b0;
    end else begin
      sinal_m <= sinal;
      sinal_s <= sinal_m;
      botao_m <= botao;
      botao_s <= botao_m;
    end
  end

  assign req = sinal_s | botao_s;

  pulso_div #(.MODULO(PRESC)) u_presc (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (estado_q != ST_IDLE),
    .clr     (estado_q == ST_IDLE),
    .tick_c  (passo)
  );

  pulso_div #(.MODULO(SCAN_DIV)) u_scan (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (1'b1),
    .clr     (1'b0),
    .tick_c  (scan_tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) estado_q <= ST_IDLE;
    else          estado_q <= estado_d;
  end

  // Off mode overrides everything; HOLD leaves on the step that exhausts the counter.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      ST_IDLE: if (req) estado_d = ST_RUN;
      ST_RUN:  if (!req) estado_d = ST_HOLD;
      ST_HOLD: begin
        if (req)                                estado_d = ST_RUN;
        else if (passo && hold_cnt == HW'(1))   estado_d = ST_IDLE;
      end
      default: estado_d = ST_IDLE;
    endcase
    if (modo == MODO_OFF) estado_d = ST_IDLE;
  end

  // Phase, blink flag, latched display mode and hold counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fase     <= 3'd0;
      pisca    <= 1'b1;
      modo_r   <= MODO_FWD;
      hold_cnt <= '0;
    end else begin
      if (estado_q == ST_IDLE) begin
        if (estado_d == ST_RUN) begin
          fase   <= 3'd0;
          pisca  <= 1'b1;
          modo_r <= modo;
        end
      end else if (passo) begin
        modo_r <= modo;
        case (modo)
          MODO_FWD:   fase  <= (fase == 3'd5) ? 3'd0 : fase + 3'd1;
          MODO_REV:   fase  <= (fase == 3'd0) ? 3'd5 : fase - 3'd1;
          MODO_BLINK: pisca <= ~pisca;
          default:    ;
        endcase
      end
      if (estado_q == ST_RUN && estado_d == ST_HOLD) begin
        hold_cnt <= HW'(HOLD_STEPS);
      end else if (estado_q == ST_HOLD && passo) begin
        hold_cnt <= hold_cnt - HW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      digito <= '0;
    end else if (scan_tick) begin
      digito <= (digito == DW'(N_DIG - 1)) ? '0 : digito + DW'(1);
    end
  end

  assign soma = SW'(fase) + SW'(digito);
  assign idx  = 3'(soma % SW'(N_FASES));

  always_comb begin
    seg_d   = 7'h00;
    anodo_d = '0;
    ativo_d = 1'b0;
    if (estado_q != ST_IDLE) begin
      ativo_d = 1'b1;
      anodo_d = ANODO_0 << digito;
      case (modo_r)
        MODO_FWD, MODO_REV: seg_d = seg_fase(idx);
        MODO_BLINK:         seg_d = pisca ? SEG_ALL : 7'h00;
        default:            seg_d = 7'h00;
      endcase
    end
  end

  // Segments and anode update on the same edge so no digit shows a neighbour's pattern.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      segmentos <= 7'h00;
      anodo     <= '0;
      ativo     <= 1'b0;
    end else begin
      segmentos <= seg_d;
      anodo     <= anodo_d;
      ativo     <= ativo_d;
    end
  end

endmodule

// File: doc/anim_segmentos.md
# anim_segmentos

Parametrised 7-segment activity animator for the agro-defence display panel. While an activity request (`sinal` or `botao`) is present, it drives a rotating single-segment animation across `N_DIG` multiplexed digits, either forward, reverse or as a blink. After the request drops, the animation continues for a programmable hold time. It replaces the fixed single-digit, six-state spinner and sits between the alarm/button logic and the display pins.

## Interface
- `N_DIG`, 4, number of multiplexed digits (≥1)
- `PRESC`, 50000, clock cycles per animation step (≥1)
- `SCAN_DIV`, 1000, clock cycles each digit stays selected (≥1)
- `HOLD_STEPS`, 12, animation steps kept after request drops (≥1)

Ports:
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `sinal`  in  1  asynchronous activity request (sensor)
- `botao`  in  1  asynchronous activity request (push-button, level)
- `modo`  in  2  00 spin forward, 01 spin reverse, 10 blink, 11 off (request ignored, forces IDLE)
- `segmentos`  out  7  active-high; bit0 = a … bit6 = g
- `anodo`  out  N_DIG  one-hot digit select, active-high
- `ativo`  out  1  high in RUN or HOLD

## Operation
- `sinal` and `botao` each pass through a 2-flop synchroniser. The synchronised request is `req = s_sinal | s_botao`.
- FSM states:
  - **IDLE**: `req` && `modo` != 11 → RUN; clears the prescaler, sets phase = 0, sets blink flag = 1.
  - **RUN**: `!req` → HOLD; loads hold counter = HOLD_STEPS; prescaler and phase keep running.
  - **HOLD**:
    - `req` → RUN; hold counter is discarded, phase is not reset.
    - On each step pulse, the hold counter decrements. A step pulse with hold counter = 1 → IDLE.
  - `modo` = 11 in any state → IDLE next cycle.
- Step pulse: the prescaler counts 0..PRESC-1 in RUN/HOLD and pulses for one cycle at PRESC-1, then wraps. The prescaler is held at 0 in IDLE.
- Phase 0..5 (a..f) updates on the step pulse:
  - `modo` 00: phase +1, wrapping 5→0.
  - `modo` 01: phase -1, wrapping 0→5.
  - `modo` 10: phase frozen; blink flag toggles.
  - `modo` is sampled only at step pulses.
- Scan: the scan counter (0..SCAN_DIV-1) and digit index (0..N_DIG-1, wraps) run in every state, including IDLE.
- Segment value for selected digit k:
  - Spin modes: one-hot bit `(phase + k) mod 6`; g always 0.
  - Blink: 7'h7F when the flag is 1, else 0.
  - IDLE: `segmentos` = 0 and `anodo` = 0.
  - RUN/HOLD: `anodo` = one-hot(k).
- All outputs are registered. `segmentos` and `anodo` always change on the same edge, so there is no ghosting.

## Timing
- Reset (async assert, any time) values:
  - FSM, synchronisers and outputs: state IDLE, synchronisers 0, `segmentos` 0, `anodo` 0, `ativo` 0.
  - Counters: phase 0, prescaler 0, scan counter 0, digit index 0, blink flag 1, hold counter 0.
- Reset mid-animation returns to IDLE immediately. The release edge behaves as if the block were freshly powered.
- Request latency: `req` rises at edge t (2-flop synchroniser output) → FSM in RUN at t+1 → lit outputs and `ativo` high at t+2. Measured from the pin this is 4 edges.
- First step pulse occurs PRESC cycles after RUN entry.
- Drop latency: the synchronised request falls → HOLD next edge → IDLE on the HOLD_STEPS-th following step pulse → outputs 0 one edge later.
- Simultaneous events:
  - Step pulse and request return in the same cycle: the phase advances and the FSM goes to RUN.
  - Step pulse and `modo` change in the same cycle: the new `modo` applies at that pulse.
- Width rules:
  - Counters are sized with `$clog2` of their modulus, minimum 1 bit.
  - `N_DIG` = 1 → `anodo` = 1'b1 in RUN/HOLD; the digit index is constant 0.
  - `(phase + k) mod 6` is computed in `$clog2(6 + N_DIG)` bits.

## Structure
- Package `anim_pkg` holds:
  - the state enum (IDLE/RUN/HOLD),
  - the `modo` encodings,
  - the segment constants SEG_A..SEG_G and SEG_ALL.
- Sub-module `pulso_div`, parametrised by modulus, with inputs enable and clear and a one-cycle tick output. It is instantiated twice: step prescaler and scan divider.
- Synchronisers are inline.

## Test plan
All scenarios use N_DIG=2, PRESC=4, SCAN_DIV=2, HOLD_STEPS=3.

- **Reset values**: reset held, toggle `sinal` → `segmentos`=0, `anodo`=0, `ativo`=0. Release with no request → outputs stay 0 for 100 cycles.
- **Forward spin**: `sinal`=1, `modo`=00 → `ativo`=1 four edges after the pin rises. Digit0 shows 7'h01, then after 4 cycles 7'h02 … 7'h20, then 7'h01. Digit1 always shows the next segment (7'h02 when digit0 shows 7'h01).
- **Reverse and blink**:
  - `modo`=01 from phase 0 → next step shows 7'h20 on digit0.
  - `modo`=10 → `segmentos` alternates 7'h7F / 7'h00 every 4 cycles on both `anodo` values.
- **Hold**:
  - Drop the request → outputs stay active for exactly 3 step pulses, then `segmentos`=0 and `anodo`=0.
  - Reassert during HOLD at step 2 → back to RUN, phase continues without reset.
- **Off mode and async reset**:
  - `modo`=11 during RUN → IDLE next cycle, outputs 0 although `botao`=1.
  - Assert `reset_n`=0 mid-step → outputs 0 without waiting for a clock edge.
